// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of the shared combinational ALU: grants one request,
// owns the ALU input registers, and returns a registered result, zero flag and done pulse.
module alu_arbiter #(
  parameter int DW          = 8,
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic [2:0]    cmd0,
  input  logic [1:0]    op0,
  input  logic [DW-1:0] a0,
  input  logic [DW-1:0] b0,
  output logic          gnt0,
  output logic          done0,
  output logic [DW-1:0] rslt0,
  output logic          zero0,
  input  logic          req1,
  input  logic [2:0]    cmd1,
  input  logic [1:0]    op1,
  input  logic [DW-1:0] a1,
  input  logic [DW-1:0] b1,
  output logic          gnt1,
  output logic          done1,
  output logic [DW-1:0] rslt1,
  output logic          zero1,
  output logic [2:0]    alu_cmd,
  output logic [1:0]    alu_op,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  input  logic [DW-1:0] alu_rslt,
  input  logic          alu_zero,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state;
  logic   owner;
  logic   last_grant;
  logic   pick1;

  // Winner if a request is sampled this cycle; on contention round-robin
  // favours the port that was not granted last.
  always_comb begin
    pick1 = 1'b0;
    if (req1 && !req0)
      pick1 = 1'b1;
    else if (req0 && req1)
      pick1 = ROUND_ROBIN ? ~last_grant : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      alu_cmd    <= '0;
      alu_op     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      rslt0      <= '0;
      rslt1      <= '0;
      zero0      <= 1'b0;
      zero1      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        // IDLE: sample requests, latch the winner's operands into the ALU registers
        IDLE: begin
          if (req0 || req1) begin
            owner      <= pick1;
            last_grant <= pick1;
            alu_cmd    <= pick1 ? cmd1 : cmd0;
            alu_op     <= pick1 ? op1  : op0;
            alu_a      <= pick1 ? a1   : a0;
            alu_b      <= pick1 ? b1   : b0;
            gnt0       <= ~pick1;
            gnt1       <= pick1;
            busy       <= 1'b1;
            state      <= EXEC;
          end
        end
        // EXEC: ALU evaluates latched operands; capture into the owner's result only
        EXEC: begin
          gnt0 <= 1'b0;
          gnt1 <= 1'b0;
          if (owner) begin
            rslt1 <= alu_rslt;
            zero1 <= alu_zero;
            done1 <= 1'b1;
          end else begin
            rslt0 <= alu_rslt;
            zero0 <= alu_zero;
            done0 <= 1'b1;
          end
          state <= RESP;
        end
        // RESP: done is visible; park the ALU on cmd 000 / op 00
        RESP: begin
          done0   <= 1'b0;
          done1   <= 1'b0;
          alu_cmd <= '0;
          alu_op  <= '0;
          alu_a   <= '0;
          alu_b   <= '0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a round-robin and a fixed-priority instance
// share the requester inputs, each driving its own behavioural ALU.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, req1;
  logic [2:0] cmd0, cmd1;
  logic [1:0] op0, op1;
  logic [7:0] a0, b0, a1, b1;

  logic       gnt0_r, gnt1_r, done0_r, done1_r, zero0_r, zero1_r, busy_r, alu_zero_r;
  logic [7:0] rslt0_r, rslt1_r, alu_a_r, alu_b_r, alu_rslt_r;
  logic [2:0] alu_cmd_r;
  logic [1:0] alu_op_r;

  logic       gnt0_f, gnt1_f, done0_f, done1_f, zero0_f, zero1_f, busy_f, alu_zero_f;
  logic [7:0] rslt0_f, rslt1_f, alu_a_f, alu_b_f, alu_rslt_f;
  logic [2:0] alu_cmd_f;
  logic [1:0] alu_op_f;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_rslt [2];
  logic       exp_zero [2];
  int         model_last;

  logic [1:0] gnt_v, done_v;
  logic [7:0] rslt_v [2];
  logic       zero_v [2];
  assign gnt_v     = {gnt1_r, gnt0_r};
  assign done_v    = {done1_r, done0_r};
  assign rslt_v[0] = rslt0_r;
  assign rslt_v[1] = rslt1_r;
  assign zero_v[0] = zero0_r;
  assign zero_v[1] = zero1_r;

  always #5 clk = ~clk;

  // Behavioural ALU: op selects dec/inc/xor, op 00 decodes cmd.
  function automatic logic [7:0] alu_ref(input logic [2:0] c, input logic [1:0] o,
                                         input logic [7:0] a, input logic [7:0] b);
    case (o)
      2'b01:   return a - 8'd1;
      2'b10:   return a + 8'd1;
      2'b11:   return a ^ b;
      default: begin
        case (c)
          3'b000:  return 8'h00;
          3'b001:  return a | b;
          3'b010:  return a + b;
          3'b011:  return a & b;
          3'b100:  return a << b[2:0];
          3'b101:  return a >> b[2:0];
          3'b110:  return ~a;
          default: return {7'b0, ^b};
        endcase
      end
    endcase
  endfunction

  assign alu_rslt_r = alu_ref(alu_cmd_r, alu_op_r, alu_a_r, alu_b_r);
  assign alu_zero_r = (alu_rslt_r == 8'h00);
  assign alu_rslt_f = alu_ref(alu_cmd_f, alu_op_f, alu_a_f, alu_b_f);
  assign alu_zero_f = (alu_rslt_f == 8'h00);

  alu_arbiter #(.DW(8), .ROUND_ROBIN(1'b1)) dut_rr (
    .clk(clk), .reset(reset),
    .req0(req0), .cmd0(cmd0), .op0(op0), .a0(a0), .b0(b0),
    .gnt0(gnt0_r), .done0(done0_r), .rslt0(rslt0_r), .zero0(zero0_r),
    .req1(req1), .cmd1(cmd1), .op1(op1), .a1(a1), .b1(b1),
    .gnt1(gnt1_r), .done1(done1_r), .rslt1(rslt1_r), .zero1(zero1_r),
    .alu_cmd(alu_cmd_r), .alu_op(alu_op_r), .alu_a(alu_a_r), .alu_b(alu_b_r),
    .alu_rslt(alu_rslt_r), .alu_zero(alu_zero_r), .busy(busy_r)
  );

  alu_arbiter #(.DW(8), .ROUND_ROBIN(1'b0)) dut_fp (
    .clk(clk), .reset(reset),
    .req0(req0), .cmd0(cmd0), .op0(op0), .a0(a0), .b0(b0),
    .gnt0(gnt0_f), .done0(done0_f), .rslt0(rslt0_f), .zero0(zero0_f),
    .req1(req1), .cmd1(cmd1), .op1(op1), .a1(a1), .b1(b1),
    .gnt1(gnt1_f), .done1(done1_f), .rslt1(rslt1_f), .zero1(zero1_f),
    .alu_cmd(alu_cmd_f), .alu_op(alu_op_f), .alu_a(alu_a_f), .alu_b(alu_b_f),
    .alu_rslt(alu_rslt_f), .alu_zero(alu_zero_f), .busy(busy_f)
  );

  // Exclusivity of gnt/done pulses on both instances, every cycle.
  always @(negedge clk) begin
    total++;
    if ((gnt0_r && gnt1_r) || (done0_r && done1_r) || ((gnt0_r || gnt1_r) && (done0_r || done1_r))) begin
      bad++;
      $display("FAIL excl_rr gnt=%b%b done=%b%b required no overlap", gnt1_r, gnt0_r, done1_r, done0_r);
    end
    total++;
    if ((gnt0_f && gnt1_f) || (done0_f && done1_f) || ((gnt0_f || gnt1_f) && (done0_f || done1_f))) begin
      bad++;
      $display("FAIL excl_fp gnt=%b%b done=%b%b required no overlap", gnt1_f, gnt0_f, done1_f, done0_f);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic r, input logic [2:0] c, input logic [1:0] o,
                          input logic [7:0] a, input logic [7:0] b);
    if (p == 0) begin
      req0 = r; cmd0 = c; op0 = o; a0 = a; b0 = b;
    end else begin
      req1 = r; cmd1 = c; op1 = o; a1 = a; b1 = b;
    end
  endtask

  task automatic apply_reset;
    reset = 1'b1;
    set_port(0, 1'b0, 3'b0, 2'b0, 8'h00, 8'h00);
    set_port(1, 1'b0, 3'b0, 2'b0, 8'h00, 8'h00);
    tick;
    tick;
    reset = 1'b0;
    exp_rslt[0] = 8'h00; exp_rslt[1] = 8'h00;
    exp_zero[0] = 1'b0;  exp_zero[1] = 1'b0;
    model_last = 1;
  endtask

  // One uncontended transaction on port p; a_after replaces operand A right after the grant.
  task automatic do_single(input int p, input logic [2:0] c, input logic [1:0] o,
                           input logic [7:0] a, input logic [7:0] b, input logic [7:0] a_after);
    int q;
    logic [7:0] e;
    q = 1 - p;
    e = alu_ref(c, o, a, b);
    set_port(p, 1'b1, c, o, a, b);
    tick;
    total++;
    if (gnt_v !== (2'b01 << p)) begin
      bad++; $display("FAIL single_gnt port=%0d got=%b required=%b", p, gnt_v, 2'b01 << p);
    end
    total++;
    if (busy_r !== 1'b1) begin
      bad++; $display("FAIL single_busy_exec got=%b required=1", busy_r);
    end
    set_port(p, 1'b0, 3'($urandom), 2'($urandom), a_after, 8'($urandom));
    tick;
    total++;
    if (done_v !== (2'b01 << p)) begin
      bad++; $display("FAIL single_done port=%0d got=%b required=%b", p, done_v, 2'b01 << p);
    end
    total++;
    if (rslt_v[p] !== e || zero_v[p] !== (e == 8'h00)) begin
      bad++; $display("FAIL single_rslt port=%0d got=%h/%b required=%h/%b", p, rslt_v[p], zero_v[p], e, e == 8'h00);
    end
    total++;
    if (rslt_v[q] !== exp_rslt[q] || zero_v[q] !== exp_zero[q]) begin
      bad++; $display("FAIL other_held port=%0d got=%h/%b required=%h/%b", q, rslt_v[q], zero_v[q], exp_rslt[q], exp_zero[q]);
    end
    exp_rslt[p] = e;
    exp_zero[p] = (e == 8'h00);
    model_last  = p;
    tick;
    total++;
    if (busy_r !== 1'b0 || done_v !== 2'b00 || gnt_v !== 2'b00) begin
      bad++; $display("FAIL single_idle busy=%b done=%b gnt=%b required 0/00/00", busy_r, done_v, gnt_v);
    end
    total++;
    if (alu_a_r !== 8'h00 || alu_cmd_r !== 3'b000 || alu_op_r !== 2'b00 || alu_rslt_r !== 8'h00) begin
      bad++; $display("FAIL idle_alu a=%h cmd=%b op=%b rslt=%h required zeros", alu_a_r, alu_cmd_r, alu_op_r, alu_rslt_r);
    end
  endtask

  task automatic test_reset;
    apply_reset;
    total++;
    if ({gnt0_r, gnt1_r, done0_r, done1_r, busy_r, zero0_r, zero1_r} !== 7'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b required=0000000", {gnt0_r, gnt1_r, done0_r, done1_r, busy_r, zero0_r, zero1_r});
    end
    total++;
    if ({rslt0_r, rslt1_r, alu_a_r, alu_b_r, alu_cmd_r, alu_op_r} !== 37'b0) begin
      bad++; $display("FAIL reset_data r0=%h r1=%h a=%h b=%h required zeros", rslt0_r, rslt1_r, alu_a_r, alu_b_r);
    end
  endtask

  task automatic test_single_and;
    do_single(0, 3'b011, 2'b00, 8'hF0, 8'h3C, 8'($urandom));
    total++;
    if (rslt0_r !== 8'h30 || zero0_r !== 1'b0 || rslt1_r !== 8'h00) begin
      bad++; $display("FAIL and_value r0=%h z0=%b r1=%h required 30/0/00", rslt0_r, zero0_r, rslt1_r);
    end
  endtask

  task automatic test_wrap;
    do_single(1, 3'b000, 2'b10, 8'hFF, 8'h00, 8'($urandom));
    total++;
    if (rslt1_r !== 8'h00 || zero1_r !== 1'b1) begin
      bad++; $display("FAIL inc_wrap got=%h/%b required=00/1", rslt1_r, zero1_r);
    end
    do_single(1, 3'b000, 2'b01, 8'h00, 8'h00, 8'($urandom));
    total++;
    if (rslt1_r !== 8'hFF || zero1_r !== 1'b0) begin
      bad++; $display("FAIL dec_wrap got=%h/%b required=FF/0", rslt1_r, zero1_r);
    end
  endtask

  task automatic test_operand_change;
    do_single(0, 3'b100, 2'b00, 8'h01, 8'h03, 8'h80);
    total++;
    if (rslt0_r !== 8'h08) begin
      bad++; $display("FAIL shift_after_grant got=%h required=08", rslt0_r);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 16; i++)
      do_single(int'($urandom_range(0, 1)), 3'($urandom), 2'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
  endtask

  // Both ports held continuously; round-robin must alternate grants every 3 cycles.
  task automatic test_contention;
    logic [2:0] c [2];
    logic [1:0] o [2];
    logic [7:0] a [2];
    logic [7:0] b [2];
    logic [7:0] e;
    int w;
    apply_reset;
    c[0] = 3'($urandom); o[0] = 2'b11; a[0] = 8'hAA; b[0] = 8'h55;
    c[1] = 3'b111;       o[1] = 2'b00; a[1] = 8'($urandom); b[1] = 8'h07;
    set_port(0, 1'b1, c[0], o[0], a[0], b[0]);
    set_port(1, 1'b1, c[1], o[1], a[1], b[1]);
    for (int s = 0; s < 6; s++) begin
      w = (model_last == 1) ? 0 : 1;
      tick;
      total++;
      if (gnt_v !== (2'b01 << w)) begin
        bad++; $display("FAIL rr_gnt slot=%0d got=%b required=%b", s, gnt_v, 2'b01 << w);
      end
      e = alu_ref(c[w], o[w], a[w], b[w]);
      c[w] = 3'($urandom); o[w] = 2'($urandom); a[w] = 8'($urandom); b[w] = 8'($urandom);
      set_port(w, (s < 5), c[w], o[w], a[w], b[w]);
      set_port(1 - w, (s < 5), c[1-w], o[1-w], a[1-w], b[1-w]);
      tick;
      total++;
      if (done_v !== (2'b01 << w) || gnt_v !== 2'b00) begin
        bad++; $display("FAIL rr_done slot=%0d done=%b gnt=%b required=%b/00", s, done_v, gnt_v, 2'b01 << w);
      end
      total++;
      if (rslt_v[w] !== e || zero_v[w] !== (e == 8'h00)) begin
        bad++; $display("FAIL rr_rslt slot=%0d got=%h/%b required=%h/%b", s, rslt_v[w], zero_v[w], e, e == 8'h00);
      end
      exp_rslt[w] = e;
      exp_zero[w] = (e == 8'h00);
      model_last  = w;
      if (s == 0) begin
        total++;
        if (rslt0_r !== 8'hFF) begin
          bad++; $display("FAIL rr_xor got=%h required=FF", rslt0_r);
        end
      end
      if (s == 1) begin
        total++;
        if (rslt1_r !== 8'h01) begin
          bad++; $display("FAIL rr_parity got=%h required=01", rslt1_r);
        end
      end
      tick;
      total++;
      if (gnt_v !== 2'b00 || busy_r !== 1'b0) begin
        bad++; $display("FAIL rr_idle slot=%0d gnt=%b busy=%b required=00/0", s, gnt_v, busy_r);
      end
    end
  endtask

  task automatic test_fixed_priority;
    logic [7:0] e0, e1;
    logic eg0, eg1, ed0, ed1;
    apply_reset;
    set_port(0, 1'b1, 3'($urandom), 2'($urandom), 8'($urandom), 8'($urandom));
    set_port(1, 1'b1, 3'($urandom), 2'($urandom), 8'($urandom), 8'($urandom));
    e0 = alu_ref(cmd0, op0, a0, b0);
    e1 = alu_ref(cmd1, op1, a1, b1);
    for (int c = 1; c <= 15; c++) begin
      tick;
      eg0 = (c % 3 == 1) && (c <= 10);
      eg1 = (c == 13);
      ed0 = (c % 3 == 2) && (c <= 11);
      ed1 = (c == 14);
      total++;
      if ({gnt1_f, gnt0_f} !== {eg1, eg0}) begin
        bad++; $display("FAIL fp_gnt cycle=%0d got=%b%b required=%b%b", c, gnt1_f, gnt0_f, eg1, eg0);
      end
      total++;
      if ({done1_f, done0_f} !== {ed1, ed0}) begin
        bad++; $display("FAIL fp_done cycle=%0d got=%b%b required=%b%b", c, done1_f, done0_f, ed1, ed0);
      end
      if (ed0) begin
        total++;
        if (rslt0_f !== e0) begin
          bad++; $display("FAIL fp_rslt0 cycle=%0d got=%h required=%h", c, rslt0_f, e0);
        end
      end
      if (ed1) begin
        total++;
        if (rslt1_f !== e1) begin
          bad++; $display("FAIL fp_rslt1 cycle=%0d got=%h required=%h", c, rslt1_f, e1);
        end
      end
      if (c == 10) req0 = 1'b0;
      if (c == 13) req1 = 1'b0;
    end
  endtask

  task automatic test_reset_exec;
    apply_reset;
    do_single(0, 3'b011, 2'b00, 8'hF0, 8'h3C, 8'($urandom));
    do_single(1, 3'b000, 2'b10, 8'h41, 8'h00, 8'($urandom));
    set_port(0, 1'b1, 3'b011, 2'b00, 8'hFF, 8'hFF);
    tick;
    total++;
    if (gnt0_r !== 1'b1) begin
      bad++; $display("FAIL rst_exec_gnt got=%b required=1", gnt0_r);
    end
    reset = 1'b1;
    req0  = 1'b0;
    tick;
    total++;
    if (done0_r !== 1'b0 || busy_r !== 1'b0 || gnt0_r !== 1'b0) begin
      bad++; $display("FAIL rst_exec_ctrl done0=%b busy=%b gnt0=%b required 0/0/0", done0_r, busy_r, gnt0_r);
    end
    total++;
    if (rslt0_r !== 8'h00 || rslt1_r !== 8'h00 || {alu_cmd_r, alu_op_r, alu_a_r, alu_b_r} !== 21'b0) begin
      bad++; $display("FAIL rst_exec_data r0=%h r1=%h alu_a=%h alu_b=%h required zeros", rslt0_r, rslt1_r, alu_a_r, alu_b_r);
    end
    reset = 1'b0;
    tick;
    total++;
    if (done0_r !== 1'b0 || busy_r !== 1'b0) begin
      bad++; $display("FAIL rst_exec_late done0=%b busy=%b required 0/0", done0_r, busy_r);
    end
    set_port(0, 1'b1, 3'($urandom), 2'($urandom), 8'($urandom), 8'($urandom));
    set_port(1, 1'b1, 3'($urandom), 2'($urandom), 8'($urandom), 8'($urandom));
    tick;
    total++;
    if (gnt_v !== 2'b01) begin
      bad++; $display("FAIL rst_last_grant got=%b required=01", gnt_v);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    tick;
    tick;
  endtask

  initial begin
    reset = 1'b1;
    set_port(0, 1'b0, 3'b0, 2'b0, 8'h00, 8'h00);
    set_port(1, 1'b0, 3'b0, 2'b0, 8'h00, 8'h00);
    test_reset;
    test_single_and;
    test_wrap;
    test_operand_change;
    test_random;
    test_contention;
    test_fixed_priority;
    test_reset_exec;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
